// File: rtl/uart_prog_loader.sv
// -----------------------------------------------------------------------------
// uart_prog_loader
//
// Loads the instruction memory from a UART byte stream. It deserialises the
// stream, parses a length-prefixed image, packs the data bytes into
// little-endian 32-bit words and issues one write strobe per word on the
// programming port. The fetch unit's prgrom consumes that port.
//
// Image format on the wire:
//   N[7:0], N[15:8], then 4*N data bytes (byte k of a word -> dat[8k+7:8k])
//   With the checksum option, one extra byte follows: the XOR of all data bytes.
//
// Build option:
//   UPG_LOADER_CHECKSUM_EN - when defined, a checksum byte must follow the
//                            image. upg_done_o is raised only if that byte
//                            matches. When undefined, done is raised together
//                            with the last word write.
//
// Ports:
//   clk         in   programming clock (10 MHz)
//   reset       in   synchronous, active-high reset
//   rx          in   UART line, idle high, asynchronous to clk
//   upg_wen_o   out  one-cycle write strobe to program memory
//   upg_adr_o   out  word address of the current write
//   upg_dat_o   out  write data, held between strobes
//   upg_done_o  out  sticky, image completely written
//   err_o       out  sticky, framing / length / checksum error
//
// RX FSM states:
//   state     | meaning
//   RX_IDLE   | line idle, waiting for a low level
//   RX_START  | half a bit into the start bit, confirming it is still low
//   RX_DATA   | sampling 8 data bits, LSB first, one per bit period
//   RX_STOP   | sampling the stop bit, emit byte or flag a framing error
//
// Protocol FSM states:
//   state     | meaning
//   P_LEN0    | next byte is N[7:0]
//   P_LEN1    | next byte is N[15:8], range-check N
//   P_DATA    | collecting data bytes into words
//   P_CSUM    | waiting for the checksum byte (checksum build only)
//   P_DONE    | image complete, further bytes ignored
//   P_ERR     | error seen, further bytes ignored
// -----------------------------------------------------------------------------
module uart_prog_loader #(
  parameter int CLKS_PER_BIT = 78,
  parameter int ADDR_W       = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  output logic              upg_wen_o,
  output logic [ADDR_W-1:0] upg_adr_o,
  output logic [31:0]       upg_dat_o,
  output logic              upg_done_o,
  output logic              err_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  // ---------------------------------------------------------------------------
  // Input synchroniser
  // ---------------------------------------------------------------------------
  logic rx_meta_q;
  logic rx_sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // ---------------------------------------------------------------------------
  // UART receiver
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  rx_state_t        rx_state_q;
  logic [CNT_W-1:0] rx_cnt_q;
  logic [2:0]       rx_bit_q;
  logic [7:0]       rx_byte_q;
  logic             byte_valid_q;
  logic             frame_err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state_q   <= RX_IDLE;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_byte_q    <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          if (!rx_sync_q) begin
            rx_state_q <= RX_START;
            rx_cnt_q   <= HALF_LAST;
          end
        end
        RX_START: begin
          if (rx_cnt_q == '0) begin
            // A start bit that is gone by mid-bit was a glitch.
            if (!rx_sync_q) begin
              rx_state_q <= RX_DATA;
              rx_cnt_q   <= BIT_LAST;
              rx_bit_q   <= '0;
            end else begin
              rx_state_q <= RX_IDLE;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q - 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt_q == '0) begin
            rx_byte_q <= {rx_sync_q, rx_byte_q[7:1]};
            rx_cnt_q  <= BIT_LAST;
            if (rx_bit_q == 3'd7) begin
              rx_state_q <= RX_STOP;
            end else begin
              rx_bit_q <= rx_bit_q + 1'b1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q - 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt_q == '0) begin
            if (rx_sync_q) begin
              byte_valid_q <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
            end
            rx_state_q <= RX_IDLE;
          end else begin
            rx_cnt_q <= rx_cnt_q - 1'b1;
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Image protocol and word writer
  // ---------------------------------------------------------------------------
`ifdef UPG_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    P_LEN0,
    P_LEN1,
    P_DATA,
    P_CSUM,
    P_DONE,
    P_ERR
  } p_state_t;
`else
  typedef enum logic [2:0] {
    P_LEN0,
    P_LEN1,
    P_DATA,
    P_DONE,
    P_ERR
  } p_state_t;
`endif

  p_state_t          p_state_q;
  logic [7:0]        len_lo_q;
  logic [ADDR_W-1:0] len_q;
  logic [1:0]        lane_q;
  logic [23:0]       word_q;
  logic              wen_q;
  logic [ADDR_W-1:0] adr_q;
  logic [31:0]       dat_q;
  logic              done_q;
  logic              err_q;
`ifdef UPG_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q;
`endif

  logic [15:0] len_n;
  logic        len_over;
  logic        len_zero;
  logic        last_word;

  assign len_n    = {rx_byte_q, len_lo_q};
  assign len_over = (len_n >> ADDR_W) != 16'd0;
  assign len_zero = (len_n == 16'd0);
  // adr_q already points at the word being completed, since the previous
  // strobe's increment lands long before the next word's bytes arrive.
  assign last_word = (({1'b0, adr_q} + 1'b1) == {1'b0, len_q});

  always_ff @(posedge clk) begin
    if (reset) begin
      p_state_q <= P_LEN0;
      len_lo_q  <= '0;
      len_q     <= '0;
      lane_q    <= '0;
      word_q    <= '0;
      wen_q     <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef UPG_LOADER_CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      wen_q <= 1'b0;
      if (wen_q) begin
        adr_q <= adr_q + 1'b1;
      end

      // A framing error after completion is harmless: the image is in memory.
      if (frame_err_q && (p_state_q != P_DONE)) begin
        err_q     <= 1'b1;
        p_state_q <= P_ERR;
      end else if (byte_valid_q) begin
        case (p_state_q)
          P_LEN0: begin
            len_lo_q  <= rx_byte_q;
            p_state_q <= P_LEN1;
          end
          P_LEN1: begin
            if (len_over) begin
              err_q     <= 1'b1;
              p_state_q <= P_ERR;
            end else if (len_zero) begin
`ifdef UPG_LOADER_CHECKSUM_EN
              p_state_q <= P_CSUM;
`else
              done_q    <= 1'b1;
              p_state_q <= P_DONE;
`endif
            end else begin
              len_q     <= len_n[ADDR_W-1:0];
              lane_q    <= '0;
              p_state_q <= P_DATA;
            end
          end
          P_DATA: begin
`ifdef UPG_LOADER_CHECKSUM_EN
            csum_q <= csum_q ^ rx_byte_q;
`endif
            lane_q <= lane_q + 1'b1;
            case (lane_q)
              2'd0: word_q[7:0]   <= rx_byte_q;
              2'd1: word_q[15:8]  <= rx_byte_q;
              2'd2: word_q[23:16] <= rx_byte_q;
              default: begin
                dat_q <= {rx_byte_q, word_q};
                wen_q <= 1'b1;
                if (last_word) begin
`ifdef UPG_LOADER_CHECKSUM_EN
                  p_state_q <= P_CSUM;
`else
                  done_q    <= 1'b1;
                  p_state_q <= P_DONE;
`endif
                end
              end
            endcase
          end
`ifdef UPG_LOADER_CHECKSUM_EN
          P_CSUM: begin
            if (rx_byte_q == csum_q) begin
              done_q    <= 1'b1;
              p_state_q <= P_DONE;
            end else begin
              err_q     <= 1'b1;
              p_state_q <= P_ERR;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

  assign upg_wen_o  = wen_q;
  assign upg_adr_o  = adr_q;
  assign upg_dat_o  = dat_q;
  assign upg_done_o = done_q;
  assign err_o      = err_q;

endmodule
